// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler and related peripherals.
// Contents: scheduler state enumeration, width helper functions and the
// default guard/hold-timeout constants reused by the SoC top.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_LOAD,
        ST_GUARD,
        ST_DRAIN
    } sched_state_e;

    localparam int unsigned DEF_GUARD_CYCLES = 2;
    localparam int unsigned DEF_HOLD_TIMEOUT = 1024;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Register width for a value range, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting index found
// searching upward from ptr, wrapping modulo N.
// Ports: req (request vector), ptr (search start), gnt (one-hot winner),
//        any (at least one request present).
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = cnt_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             any
);

    // Rotating scan; the first hit wins and masks later candidates.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!any && req[PTR_W'((32'(ptr) + k) % N)]) begin
                gnt[PTR_W'((32'(ptr) + k) % N)] = 1'b1;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one byte-wide UART transmitter between NREQ requesters. Grants are
// per message (burst ending in last), round-robin between messages; each
// byte is sent with a one-cycle load pulse, a busy-settle guard and a drain
// wait. A hold timeout revokes a grant from a stalled requester.
// Ports: clk, reset (sync, active-high); req_valid/req_data/req_last in and
//        req_ready out per requester; tx_data/tx_load out and tx_busy in
//        towards the UART core; grant (one-hot owner) and timeout (pulse) out.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_ready,
    output logic [7:0]          tx_data,
    output logic                tx_load,
    input  logic                tx_busy,
    output logic [NREQ-1:0]     grant,
    output logic                timeout
);

    localparam int unsigned PTR_W   = cnt_width(NREQ);
    localparam int unsigned HOLD_W  = cnt_width(HOLD_TIMEOUT + 1);
    localparam int unsigned GUARD_W = cnt_width(GUARD_CYCLES);

    sched_state_e       state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]   own_q, own_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
    logic               last_q, last_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_load_q, tx_load_d;
    logic               timeout_q, timeout_d;
    logic [NREQ-1:0]    req_ready_q, req_ready_d;

    logic [NREQ-1:0]    arb_gnt;
    logic               arb_any;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic               xfer;
    logic [7:0]         req_bytes [NREQ];

    rr_arbiter #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    // Byte lanes and one-hot-to-index of the arbiter winner.
    always_comb begin
        arb_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            req_bytes[k] = req_data[8*k +: 8];
            if (arb_gnt[k]) begin
                arb_idx = PTR_W'(k);
            end
        end
    end

    // After releasing the owner, the next requester up wins ties.
    assign ptr_next = PTR_W'((32'(own_q) + 1) % NREQ);
    assign xfer     = |(req_valid & req_ready_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            own_q       <= '0;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            guard_cnt_q <= '0;
            last_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            timeout_q   <= 1'b0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            own_q       <= own_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            last_q      <= last_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            timeout_q   <= timeout_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        own_d       = own_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        guard_cnt_d = guard_cnt_q;
        last_d      = last_q;
        tx_data_d   = tx_data_q;
        timeout_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Transmitter is always drained before release, so busy is not consulted.
                if (arb_any) begin
                    grant_d    = arb_gnt;
                    own_d      = arb_idx;
                    hold_cnt_d = '0;
                    state_d    = ST_READY;
                end
            end
            ST_READY: begin
                // A transfer on the threshold cycle takes priority over the timeout.
                if (xfer) begin
                    tx_data_d = req_bytes[own_q];
                    last_d    = req_last[own_q];
                    state_d   = ST_LOAD;
                end else if (HOLD_TIMEOUT != 0 &&
                             hold_cnt_q == HOLD_W'(HOLD_TIMEOUT - 1)) begin
                    grant_d   = '0;
                    rr_ptr_d  = ptr_next;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_LOAD: begin
                guard_cnt_d = '0;
                state_d     = ST_GUARD;
            end
            ST_GUARD: begin
                // Busy may not have risen yet, so it is ignored here.
                if (guard_cnt_q == GUARD_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    guard_cnt_d = guard_cnt_q + GUARD_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = ptr_next;
                        state_d  = ST_IDLE;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = ST_READY;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_load_d   = (state_d == ST_LOAD);
        req_ready_d = (state_d == ST_READY) ? grant_d : '0;
    end

    assign req_ready = req_ready_q;
    assign tx_data   = tx_data_q;
    assign tx_load   = tx_load_q;
    assign grant     = grant_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic, with
// every cycle compared against a timestamp-based reference model.
module tb_uart_tx_sched;

    localparam int NREQ  = 2;
    localparam int GUARD = 2;
    localparam int HOLD  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_load;
    logic              tx_busy;
    logic [NREQ-1:0]   grant;
    logic              timeout;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NREQ         (NREQ),
        .GUARD_CYCLES (GUARD),
        .HOLD_TIMEOUT (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .timeout   (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester byte queues: {last, data}.
    logic [8:0] rq0[$];
    logic [8:0] rq1[$];
    bit         en [NREQ];
    int         busy_len  = 0;
    bit         busy_rand = 0;
    int         bcnt      = 0;

    // Observations taken by the monitor.
    logic [NREQ-1:0] xfer_seen = '0;
    bit              load_seen = 0;
    int              load_cnt  = 0;
    int              to_cnt    = 0;
    int              to_last   = -1;
    int              xf_cyc[$];
    int              ld_req[$];
    logic [7:0]      ld_byte[$];

    // Reference model state (values valid for the current cycle).
    bit         m_on       = 0;
    int         m_owner    = -1;
    int         m_ptr      = 0;
    bit         m_ready    = 0;
    bit         m_inflight = 0;
    int         m_xfer     = -100;
    bit         m_last     = 0;
    logic [7:0] m_data     = 8'h00;
    int         m_idle_run = 0;
    bit         m_to       = 0;
    bit         m_found;
    bit         m_nto;
    int         m_pick;
    int         m_cand;
    int         g_idx;
    logic [NREQ-1:0] exp_grant_v;
    logic [NREQ-1:0] exp_ready_v;

    always @(negedge clk) begin
        cyc++;
        if (m_on) begin
            exp_grant_v = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
            exp_ready_v = m_ready ? exp_grant_v : '0;
            check_eq("grant", 32'(grant), 32'(exp_grant_v));
            check_eq("req_ready", 32'(req_ready), 32'(exp_ready_v));
            check_eq("tx_load", 32'(tx_load), 32'(m_inflight && (cyc == m_xfer + 1)));
            check_eq("tx_data", 32'(tx_data), 32'(m_data));
            check_eq("timeout", 32'(timeout), 32'(m_to));
        end

        xfer_seen = req_valid & req_ready;
        load_seen = tx_load;
        if (|xfer_seen) xf_cyc.push_back(cyc);
        if (tx_load) begin
            load_cnt++;
            g_idx = -1;
            for (int k = 0; k < NREQ; k++) if (grant[k]) g_idx = k;
            ld_req.push_back(g_idx);
            ld_byte.push_back(tx_data);
        end
        if (timeout) begin
            to_cnt++;
            to_last = cyc;
        end

        // Advance the model to the next cycle.
        m_nto = 0;
        if (reset) begin
            m_on = 1; m_owner = -1; m_ptr = 0; m_ready = 0; m_inflight = 0;
            m_xfer = -100; m_last = 0; m_data = 8'h00; m_idle_run = 0;
        end else if (m_on) begin
            if (m_owner < 0) begin
                m_found = 0;
                m_pick  = 0;
                for (int k = 0; k < NREQ; k++) begin
                    m_cand = (m_ptr + k) % NREQ;
                    if (!m_found && req_valid[m_cand]) begin
                        m_found = 1;
                        m_pick  = m_cand;
                    end
                end
                if (m_found) begin
                    m_owner = m_pick; m_ready = 1; m_idle_run = 0;
                end
            end else if (m_ready) begin
                if (req_valid[m_owner]) begin
                    m_data = req_data[8*m_owner +: 8];
                    m_last = req_last[m_owner];
                    m_inflight = 1; m_xfer = cyc; m_ready = 0;
                end else begin
                    m_idle_run++;
                    if (HOLD > 0 && m_idle_run == HOLD) begin
                        m_nto = 1; m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_ready = 0;
                    end
                end
            end else if (m_inflight && cyc >= m_xfer + 2 + GUARD && !tx_busy) begin
                m_inflight = 0;
                if (m_last) begin
                    m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
                end else begin
                    m_ready = 1; m_idle_run = 0;
                end
            end
        end
        m_to = m_nto;
    end

    // Requester and UART-busy drivers.
    initial begin
        logic [8:0] junk;
        req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (xfer_seen[0] && rq0.size() > 0) junk = rq0.pop_front();
            if (xfer_seen[1] && rq1.size() > 0) junk = rq1.pop_front();
            if (load_seen) bcnt = busy_rand ? int'($urandom_range(0, 25)) : busy_len;
            tx_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
            req_valid[0] = en[0] && rq0.size() > 0;
            {req_last[0], req_data[7:0]} = (rq0.size() > 0) ? rq0[0] : 9'h000;
            req_valid[1] = en[1] && rq1.size() > 0;
            {req_last[1], req_data[15:8]} = (rq1.size() > 0) ? rq1[0] : 9'h000;
        end
    end

    task automatic push_byte(input int r, input logic [7:0] b, input bit last);
        if (r == 0) rq0.push_back({last, b});
        else        rq1.push_back({last, b});
    endtask

    task automatic push_msg(input int r, input int len);
        for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(rq0.size() == 0 && rq1.size() == 0 && grant == '0 &&
                     m_owner < 0 && !m_inflight) && n < max_cyc);
        check_eq({tag, "_bound"}, 32'(n >= max_cyc), 32'(0));
    endtask

    task automatic wait_count(input int base, input bit loads, input int max_cyc, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (((loads ? load_cnt : xf_cyc.size()) <= base) && n < max_cyc);
        check_eq({tag, "_bound"}, 32'(n >= max_cyc), 32'(0));
    endtask

    initial begin
        int lb, xb, tb0, t0;
        reset = 1'b1;
        en[0] = 0; en[1] = 0;
        repeat (3) @(posedge clk);
        tick();
        check_eq("rst_grant", 32'(grant), 32'(0));
        check_eq("rst_ready", 32'(req_ready), 32'(0));
        check_eq("rst_load", 32'(tx_load), 32'(0));
        check_eq("rst_data", 32'(tx_data), 32'(0));
        check_eq("rst_timeout", 32'(timeout), 32'(0));
        @(posedge clk); #1 reset = 1'b0;

        // Single message with a 20-cycle busy after each load.
        busy_len = 20;
        lb = load_cnt; xb = xf_cyc.size();
        push_byte(0, 8'h48, 0); push_byte(0, 8'h69, 1); en[0] = 1;
        wait_idle(300, "single");
        check_eq("single_loads", 32'(load_cnt - lb), 32'(2));
        check_eq("single_b0", 32'(ld_byte[lb]), 32'h48);
        check_eq("single_b1", 32'(ld_byte[lb + 1]), 32'h69);
        check_eq("single_gap", 32'(xf_cyc[xb + 1] - xf_cyc[xb]), 32'(3 + 20));
        check_eq("single_grant_clr", 32'(grant), 32'(0));

        // Contention from reset release; req0 wins, then req1, then req0 again.
        @(posedge clk); #1 reset = 1'b1;
        busy_rand = 1;
        push_byte(0, 8'hA0, 0); push_byte(0, 8'hA1, 1);
        push_byte(1, 8'hB0, 0); push_byte(1, 8'hB1, 1);
        en[0] = 1; en[1] = 1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lb = load_cnt;
        wait_idle(400, "cont");
        check_eq("cont_r0", 32'(ld_req[lb]), 32'(0));
        check_eq("cont_r1", 32'(ld_req[lb + 1]), 32'(0));
        check_eq("cont_r2", 32'(ld_req[lb + 2]), 32'(1));
        check_eq("cont_r3", 32'(ld_req[lb + 3]), 32'(1));
        check_eq("cont_b1", 32'(ld_byte[lb + 1]), 32'hA1);
        check_eq("cont_b2", 32'(ld_byte[lb + 2]), 32'hB0);
        lb = load_cnt;
        push_msg(0, 2); push_msg(1, 2);
        wait_idle(400, "cont2");
        check_eq("cont_wrap", 32'(ld_req[lb]), 32'(0));
        check_eq("cont_wrap_next", 32'(ld_req[lb + 2]), 32'(1));

        // Lock: req1 arrives mid-message and waits for req0's last byte.
        busy_rand = 0; busy_len = 10;
        lb = load_cnt; xb = xf_cyc.size();
        push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 0); push_byte(0, 8'h03, 1);
        wait_count(xb, 0, 100, "lock_first");
        push_byte(1, 8'h10, 1);
        wait_idle(400, "lock");
        check_eq("lock_r1", 32'(ld_req[lb + 1]), 32'(0));
        check_eq("lock_r2", 32'(ld_req[lb + 2]), 32'(0));
        check_eq("lock_r3", 32'(ld_req[lb + 3]), 32'(1));
        check_eq("lock_b3", 32'(ld_byte[lb + 3]), 32'h10);

        // Timeout: req0 sends a non-last byte and goes quiet; req1 then wins.
        busy_len = 0;
        tb0 = to_cnt; xb = xf_cyc.size(); lb = load_cnt;
        push_byte(0, 8'h5A, 0);
        wait_count(xb, 0, 100, "to_first");
        t0 = xf_cyc[xb];
        push_byte(1, 8'hA5, 1);
        wait_idle(200, "to");
        check_eq("to_pulses", 32'(to_cnt - tb0), 32'(1));
        check_eq("to_delay", 32'(to_last - t0), 32'(3 + GUARD + HOLD));
        check_eq("to_next_req", 32'(ld_req[lb + 1]), 32'(1));
        check_eq("to_next_byte", 32'(ld_byte[lb + 1]), 32'hA5);

        // Reset during GUARD.
        busy_len = 5;
        lb = load_cnt;
        push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 1);
        wait_count(lb, 1, 100, "rstm_load");
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        tick();
        check_eq("rstm_grant", 32'(grant), 32'(0));
        check_eq("rstm_ready", 32'(req_ready), 32'(0));
        check_eq("rstm_load", 32'(tx_load), 32'(0));
        check_eq("rstm_data", 32'(tx_data), 32'(0));
        check_eq("rstm_timeout", 32'(timeout), 32'(0));
        lb = load_cnt; xb = xf_cyc.size();
        wait_count(xb, 0, 100, "rstm_xfer");
        check_eq("rstm_no_load", 32'(load_cnt - lb), 32'(0));
        wait_idle(200, "rstm");

        // Busy never asserts: fixed byte spacing.
        busy_len = 0;
        xb = xf_cyc.size();
        push_msg(0, 4);
        wait_idle(200, "fast");
        for (int i = 1; i < 4; i++)
            check_eq("fast_gap", 32'(xf_cyc[xb + i] - xf_cyc[xb + i - 1]), 32'(3 + GUARD));

        // Randomized traffic with stalls and random busy lengths.
        busy_rand = 1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            tick();
            r = int'($urandom_range(0, NREQ - 1));
            if ($urandom_range(0, 39) == 0 && (r == 0 ? rq0.size() : rq1.size()) < 6)
                push_msg(r, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 29) == 0) en[r] = !en[r];
        end
        en[0] = 1; en[1] = 1;
        wait_idle(5000, "rand_drain");
        check_eq("load_vs_xfer", 32'(load_cnt), 32'(xf_cyc.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one byte-wide UART transmitter between `NREQ` byte-stream requesters, e.g. firmware console and a hardware debug/log source. It sits between the requesters and the UART core's `load`/`d`/`txbusy` port. It grants the transmitter per message (a burst ending in `last`), round-robin between messages. It sequences every byte with a one-cycle load pulse and a busy-settle guard. A hold timeout stops a stalled requester from keeping the transmitter.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `GUARD_CYCLES`, 2: cycles after `tx_load` during which `tx_busy` is ignored (≥1).
- `HOLD_TIMEOUT`, 1024: consecutive idle cycles in READY before the grant is revoked; 0 disables the timeout.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  8*NREQ  requester i byte on bits [8i+7:8i].
- `req_last`  in  NREQ  byte is the final byte of its message.
- `req_ready`  out  NREQ  per-requester accept.
- `tx_data`  out  8  byte to UART core `d`.
- `tx_load`  out  1  one-cycle load strobe to UART core.
- `tx_busy`  in  1  UART core transmit busy.
- `grant`  out  NREQ  one-hot current owner; all zero when idle.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- Transfer: a byte transfers on requester i when `req_valid[i] && req_ready[i]`.
- `req_ready` is a function of registered state only. It is `(state==READY) && grant[i]`. It never depends on `req_valid`.
- IDLE
  - If any `req_valid` is high: pick the first valid index searching upward from `rr_ptr`, wrapping modulo NREQ.
  - Register that index into `grant` and go to READY.
  - Arbitration ignores `tx_busy`. DRAIN always precedes release, so the transmitter is idle here.
- READY
  - `req_ready[g]=1`.
  - On transfer: capture `tx_data<=byte`, `last_q<=req_last[g]`, go to LOAD.
  - Without transfer: increment `hold_cnt`.
  - If `HOLD_TIMEOUT>0` and this is the HOLD_TIMEOUT-th consecutive cycle without transfer:
    - clear `grant`;
    - set `rr_ptr<=(g+1) mod NREQ`;
    - set `timeout<=1`;
    - go to IDLE.
  - `hold_cnt` clears on every entry to READY. Its width is clog2(HOLD_TIMEOUT+1).
- LOAD
  - `tx_load=1` for exactly this cycle; `tx_data` is stable.
  - Go to GUARD.
- GUARD
  - Count GUARD_CYCLES cycles, ignoring `tx_busy`.
  - Then go to DRAIN.
- DRAIN
  - Wait for `tx_busy==0`.
  - If `last_q`: clear `grant`, set `rr_ptr<=(g+1) mod NREQ`, go to IDLE.
  - Otherwise go back to READY with the grant unchanged.
- Grant lock: a granted requester keeps the transmitter until its `last` byte drains or it times out. Other requesters' valids are ignored meanwhile.
- `tx_data` holds its value until the next capture.
- Requesters whose `req_valid` drops mid-message are legal; only the timeout applies.

## Timing
- Reset values: state IDLE, `grant=0`, `req_ready=0`, `tx_load=0`, `tx_data=8'h00`, `timeout=0`, `rr_ptr=0`, `hold_cnt=0`, `last_q=0`.
- Reset mid-operation: all of the above takes effect the next cycle. The message is abandoned and no `tx_load` is issued after reset. The UART core is not reset by this block.
- Arbitration latency: valid seen in IDLE at cycle T gives `grant` and `req_ready` high at T+1.
- Byte latency: transfer at cycle T gives `tx_load` at T+1, GUARD over T+2..T+1+GUARD_CYCLES, and DRAIN from T+2+GUARD_CYCLES.
- Earliest next `req_ready` is T+2+GUARD_CYCLES+1 when `tx_busy` is already low.
- `tx_load` is never high on two consecutive cycles.
- `tx_load` is never high while the block is in DRAIN with `tx_busy=1`.
- `timeout` is registered: high for exactly the first IDLE cycle after revocation.
- Simultaneous valids in IDLE: `rr_ptr` breaks the tie. After releasing requester i, requester i+1 (mod NREQ) wins a tie.
- `req_valid` asserting on the same cycle as the timeout threshold counts as a transfer, not a timeout.

## Structure
- Shared package `uart_sched_pkg` holds:
  - the state enumeration (IDLE, READY, LOAD, GUARD, DRAIN);
  - a `clog2` function;
  - the default GUARD_CYCLES/HOLD_TIMEOUT constants, reused by the SoC top.
- One sub-module, `rr_arbiter`: combinational round-robin pick of the first valid index from a start pointer. Inputs are `req` and `ptr`; outputs are a one-hot `gnt` and `any`. It is reusable for other shared peripherals.
- FSM, counters and the data register live in `uart_tx_sched`.

## Test plan
- Single message: req0 sends 8'h48, 8'h69 (last), with a busy model high for 20 cycles after each load. Required:
  - exactly two `tx_load` pulses, `tx_data` 8'h48 then 8'h69;
  - second `req_ready` no earlier than drain+1;
  - `grant` returns to 0.
- Contention: req0 and req1 both hold 2-byte messages at reset release. Required:
  - order is req0 bytes then req1 bytes, with no interleave;
  - both valid again afterwards → req0 next (`rr_ptr` wrapped).
- Lock: req1 valid while req0's message is mid-flight. Required:
  - `req_ready[1]` stays 0 until req0's last byte drains and `grant` clears.
- Timeout: `HOLD_TIMEOUT=16`; req0 sends one non-last byte then drops valid. Required:
  - `timeout` is high 1 cycle, 16 cycles after re-entering READY;
  - pending req1 is then granted.
- Reset mid-byte: assert `reset` in GUARD. Required:
  - next cycle all outputs at reset values;
  - no further `tx_load` until a new transfer.
- Busy already low: a busy model that never asserts. Required:
  - byte spacing is exactly 3+GUARD_CYCLES cycles between transfers of a message.
